// File: rtl/dmem_bridge_pkg.sv
// Shared definitions for the data-memory bridge: FSM states, bus size codes
// and the kseg0/kseg1 translation constants.
package dmem_bridge_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StReq  = 2'd1,
        StWait = 2'd2,
        StDone = 2'd3
    } bridge_state_e;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    // kseg0 (0x8...) and kseg1 (0xA...) share addr[31:30] == 2'b10
    localparam logic [1:0]  KSEG_SEG  = 2'b10;
    localparam logic [31:0] KSEG_MASK = 32'h1FFF_FFFF;

endpackage

// File: rtl/dmem_bridge.sv
// M-stage data-memory bridge: turns core load/store requests into a
// request/addr_ok/data_ok bus transaction and stalls the pipeline meanwhile.
module dmem_bridge
    import dmem_bridge_pkg::*;
#(
    parameter bit KSEG_XLATE = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_memread,
    input  logic        cpu_memwrite,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic [3:0]  cpu_sel,
    input  logic        cpu_except,
    output logic [31:0] cpu_rdata,
    output logic        cpu_stall,
    output logic        data_req,
    output logic        data_wr,
    output logic [1:0]  data_size,
    output logic [31:0] data_addr,
    output logic [31:0] data_wdata,
    input  logic        data_addr_ok,
    input  logic        data_data_ok,
    input  logic [31:0] data_rdata
);

    bridge_state_e r_state;
    logic          r_req;
    logic          r_wr;
    logic [1:0]    r_size;
    logic [31:0]   r_addr;
    logic [31:0]   r_wdata;
    logic [31:0]   r_rdata;

    logic          w_access;
    logic [1:0]    w_size;
    logic [31:0]   w_vaddr;
    logic [31:0]   w_paddr;

    always_comb begin
        w_access = (cpu_memread | cpu_memwrite) & ~cpu_except
                   & ~(cpu_memwrite & (cpu_sel == 4'b0000));

        w_size = SZ_WORD;
        if (cpu_memwrite) begin
            case (cpu_sel)
                4'b0011, 4'b1100:                   w_size = SZ_HALF;
                4'b0001, 4'b0010, 4'b0100, 4'b1000: w_size = SZ_BYTE;
                default:                            w_size = SZ_WORD;
            endcase
        end

        // Loads always fetch the whole word; the core extracts lanes.
        w_vaddr = cpu_memwrite ? cpu_addr : {cpu_addr[31:2], 2'b00};
        if (KSEG_XLATE && (w_vaddr[31:30] == KSEG_SEG)) begin
            w_paddr = w_vaddr & KSEG_MASK;
        end else begin
            w_paddr = w_vaddr;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
            r_req   <= 1'b0;
            r_wr    <= 1'b0;
            r_size  <= 2'd0;
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
            r_rdata <= 32'd0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (w_access) begin
                        r_state <= StReq;
                        r_req   <= 1'b1;
                        r_wr    <= cpu_memwrite;
                        r_size  <= w_size;
                        r_addr  <= w_paddr;
                        r_wdata <= cpu_wdata;
                    end
                end
                StReq: begin
                    if (data_addr_ok) begin
                        r_req <= 1'b0;
                        if (data_data_ok) begin
                            r_rdata <= data_rdata;
                            r_state <= StDone;
                        end else begin
                            r_state <= StWait;
                        end
                    end
                end
                StWait: begin
                    if (data_data_ok) begin
                        r_rdata <= data_rdata;
                        r_state <= StDone;
                    end
                end
                StDone:  r_state <= StIdle;
                default: r_state <= StIdle;
            endcase
        end
    end

    // Stall rises combinationally in the issuing IDLE cycle so the M-stage holds.
    assign cpu_stall  = ~rst & ((r_state == StReq) | (r_state == StWait)
                                | ((r_state == StIdle) & w_access));
    assign data_req   = r_req;
    assign data_wr    = r_wr;
    assign data_size  = r_size;
    assign data_addr  = r_addr;
    assign data_wdata = r_wdata;
    assign cpu_rdata  = r_rdata;

endmodule

// File: tb/tb_dmem_bridge.sv
// Scoreboard bench for dmem_bridge: stimulus pushes expected bus requests and
// completions, independent monitors pop and compare against the DUT.
module tb_dmem_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_memread, cpu_memwrite, cpu_except;
    logic [31:0] cpu_addr, cpu_wdata;
    logic [3:0]  cpu_sel;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    typedef struct {
        bit          is_read;
        logic [31:0] rdata;
        int          stalls;
    } done_t;

    req_t  q_req[$];
    done_t q_done[$];

    dmem_bridge #(.KSEG_XLATE(1'b1)) u_dut (
        .clk          (clk),
        .rst          (rst),
        .cpu_memread  (cpu_memread),
        .cpu_memwrite (cpu_memwrite),
        .cpu_addr     (cpu_addr),
        .cpu_wdata    (cpu_wdata),
        .cpu_sel      (cpu_sel),
        .cpu_except   (cpu_except),
        .cpu_rdata    (cpu_rdata),
        .cpu_stall    (cpu_stall),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: bus request the spec's rules imply for a core request.
    function automatic logic [1:0] model_size(input logic wr, input logic [3:0] sel);
        if (!wr)                        return 2'd2;
        if (sel == 4'b1111)             return 2'd2;
        if (sel == 4'b0011 || sel == 4'b1100) return 2'd1;
        if ($countones(sel) == 1)       return 2'd0;
        return 2'd2;
    endfunction

    function automatic logic [31:0] model_addr(input logic wr, input logic [31:0] a);
        logic [31:0] v;
        v = wr ? a : (a / 4) * 4;
        if (v[31:30] == 2'b10) v = {3'b000, v[28:0]};
        return v;
    endfunction

    // Bus-side monitor: every cycle data_req is high must match the head request.
    always @(negedge clk) begin
        if (!rst && data_req) begin
            if (q_req.size() == 0) begin
                chk("unexpected_data_req", 32'd1, 32'd0);
            end else begin
                chk("bus_wr", {31'd0, data_wr}, {31'd0, q_req[0].wr});
                chk("bus_size", {30'd0, data_size}, {30'd0, q_req[0].size});
                chk("bus_addr", data_addr, q_req[0].addr);
                if (q_req[0].wr) chk("bus_wdata", data_wdata, q_req[0].wdata);
                if (data_addr_ok) void'(q_req.pop_front());
            end
        end
    end

    // Core-side monitor: a stall burst ends in DONE; check its length and rdata.
    int stall_cnt = 0;
    always @(negedge clk) begin
        done_t e;
        if (rst) begin
            stall_cnt = 0;
        end else if (cpu_stall) begin
            stall_cnt++;
        end else if (stall_cnt > 0) begin
            if (q_done.size() == 0) begin
                chk("unexpected_completion", 32'd1, 32'd0);
            end else begin
                e = q_done.pop_front();
                chk("stall_cycles", stall_cnt, e.stalls);
                chk("done_req_low", {31'd0, data_req}, 32'd0);
                if (e.is_read) chk("cpu_rdata", cpu_rdata, e.rdata);
            end
            stall_cnt = 0;
        end
    end

    task automatic bus_idle();
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
        data_rdata   = $urandom;
    endtask

    task automatic cpu_idle();
        cpu_memread  = 1'b0;
        cpu_memwrite = 1'b0;
        cpu_except   = 1'b0;
        cpu_sel      = 4'b0000;
        cpu_addr     = $urandom;
        cpu_wdata    = $urandom;
    endtask

    // Caller is at posedge+1. a_lat = cycles of addr_ok=0 in REQ; d_lat = WAIT
    // cycles before data_ok (0 = data_ok together with addr_ok).
    task automatic run_txn(input logic rd, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] sel, input logic exc,
                           input int a_lat, input int d_lat, input logic [31:0] rdata);
        bit    acc;
        req_t  r;
        done_t d;
        acc = (rd || wr) && !exc && !(wr && sel == 4'b0000);
        if (acc) begin
            r.wr = wr; r.size = model_size(wr, sel); r.addr = model_addr(wr, addr);
            r.wdata = wdata;
            q_req.push_back(r);
            d.is_read = !wr; d.rdata = rdata;
            d.stalls = 1 + (a_lat + 1) + d_lat;
            q_done.push_back(d);
        end
        cpu_memread = rd; cpu_memwrite = wr; cpu_addr = addr; cpu_wdata = wdata;
        cpu_sel = sel; cpu_except = exc;
        if (!acc) begin
            repeat (2) begin
                @(negedge clk);
                chk("noacc_stall", {31'd0, cpu_stall}, 32'd0);
                chk("noacc_req", {31'd0, data_req}, 32'd0);
                @(posedge clk); #1;
            end
            cpu_idle();
            return;
        end
        @(posedge clk); #1;
        repeat (a_lat) begin @(posedge clk); #1; end
        data_addr_ok = 1'b1;
        if (d_lat == 0) begin data_data_ok = 1'b1; data_rdata = rdata; end
        @(posedge clk); #1;
        bus_idle();
        if (d_lat > 0) begin
            repeat (d_lat - 1) begin @(posedge clk); #1; end
            data_data_ok = 1'b1; data_rdata = rdata;
            @(posedge clk); #1;
            bus_idle();
        end
        // DONE: core request still presented, stray bus responses must be ignored
        data_addr_ok = 1'($urandom); data_data_ok = 1'($urandom);
        data_rdata = ~rdata;
        @(posedge clk); #1;
        cpu_idle();
        data_data_ok = 1'b1;
        @(negedge clk);
        chk("idle_stall", {31'd0, cpu_stall}, 32'd0);
        chk("idle_req", {31'd0, data_req}, 32'd0);
        if (!wr) chk("rdata_hold", cpu_rdata, rdata);
        @(posedge clk); #1;
        bus_idle();
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_req"}, {31'd0, data_req}, 32'd0);
        chk({tag, "_wr"}, {31'd0, data_wr}, 32'd0);
        chk({tag, "_size"}, {30'd0, data_size}, 32'd0);
        chk({tag, "_addr"}, data_addr, 32'd0);
        chk({tag, "_wdata"}, data_wdata, 32'd0);
        chk({tag, "_rdata"}, cpu_rdata, 32'd0);
        chk({tag, "_stall"}, {31'd0, cpu_stall}, 32'd0);
    endtask

    task automatic reset_mid_txn();
        req_t  r;
        done_t d;
        r.wr = 1'b0; r.size = 2'd2; r.addr = 32'h0000_2000; r.wdata = 32'd0;
        q_req.push_back(r);
        d.is_read = 1'b1; d.rdata = 32'd0; d.stalls = 0;
        q_done.push_back(d);
        cpu_memread = 1'b1; cpu_addr = 32'h0000_2000; cpu_sel = 4'hF;
        @(posedge clk); #1;
        data_addr_ok = 1'b1;
        @(posedge clk); #1;
        bus_idle();
        @(negedge clk);
        chk("wait_stall", {31'd0, cpu_stall}, 32'd1);
        chk("wait_req", {31'd0, data_req}, 32'd0);
        rst = 1'b1;
        cpu_idle();
        #1;
        check_zero_outputs("midrst");
        q_req.delete();
        q_done.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        data_data_ok = 1'b1; data_rdata = 32'hBAD0_BAD0;
        @(negedge clk);
        chk("late_ok_stall", {31'd0, cpu_stall}, 32'd0);
        @(posedge clk); #1;
        bus_idle();
        @(negedge clk);
        check_zero_outputs("late_ok");
        @(posedge clk); #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    logic [3:0] sel_tab [8] = '{4'b1111, 4'b0011, 4'b1100, 4'b0001,
                                4'b0010, 4'b0100, 4'b1000, 4'b0000};

    initial begin
        rst = 1'b1;
        cpu_idle();
        bus_idle();
        repeat (2) @(posedge clk);
        #1;
        check_zero_outputs("rst");
        rst = 1'b0;
        @(posedge clk); #1;
        check_zero_outputs("post_rst");

        // Load through kseg0, addr_ok cycle 1, data_ok cycle 2.
        run_txn(1'b1, 1'b0, 32'h8000_0104, 32'h0, 4'hF, 1'b0, 0, 1, 32'hDEAD_BEEF);
        // Byte store through kseg1 with addr_ok held low 3 cycles.
        run_txn(1'b0, 1'b1, 32'hA000_0012, 32'h00AB_0000, 4'b0100, 1'b0, 3, 1, 32'h0);
        // read+write together is a write.
        run_txn(1'b1, 1'b1, 32'h0000_0042, 32'h1234_0000, 4'b1100, 1'b0, 0, 2, 32'h0);
        // Suppressed: exception, and empty-lane store.
        run_txn(1'b1, 1'b0, 32'h0000_0100, 32'h0, 4'hF, 1'b1, 0, 1, 32'h0);
        run_txn(1'b0, 1'b1, 32'h0000_0100, 32'h5555_5555, 4'b0000, 1'b0, 0, 1, 32'h0);
        reset_mid_txn();
        run_txn(1'b1, 1'b0, 32'h1000_0008, 32'h0, 4'hF, 1'b0, 0, 1, 32'hCAFE_F00D);
        // addr_ok and data_ok together: 2 stall cycles.
        run_txn(1'b1, 1'b0, 32'hC000_0003, 32'h0, 4'hF, 1'b0, 0, 0, 32'h0BAD_CAFE);

        for (int i = 0; i < 60; i++) begin
            logic        rd, wr, exc;
            logic [3:0]  sel;
            logic [31:0] addr;
            rd   = 1'($urandom);
            wr   = 1'($urandom);
            if (!rd && !wr) rd = 1'b1;
            exc  = ($urandom_range(0, 7) == 0);
            sel  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : sel_tab[$urandom_range(0, 7)];
            addr = $urandom;
            run_txn(rd, wr, addr, $urandom, sel, exc, $urandom_range(0, 3),
                    $urandom_range(0, 3), $urandom);
        end

        repeat (3) @(posedge clk);
        chk("req_queue_drained", q_req.size(), 32'd0);
        chk("done_queue_drained", q_done.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
